stdp_update_scheduler: RTL and testbench

//   Tracks spike timing for N_SYN pre-synaptic inputs converging on one post neuron and

---
 rtl/stdp_update_scheduler.sv | 156 +++++++++++++++
 tb/tb_stdp_update_scheduler.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/stdp_update_scheduler.sv
// STDP event detector and round-robin update scheduler for N_SYN synapses onto one post neuron.
// Optional: define STDP_SCHED_STATS_EN to add the saturating upd_count_o transfer counter.
module stdp_update_scheduler #(
  parameter int N_SYN  = 4,
  parameter int TW     = 8,
  parameter int WINDOW = 16,
  localparam int IW    = $clog2(N_SYN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SYN-1:0] pre_spike_i,
  input  logic             post_spike_i,
  output logic             upd_valid_o,
  input  logic             upd_ready_i,
  output logic [IW-1:0]    upd_idx_o,
  output logic             upd_ltp_o,
  output logic [TW-1:0]    upd_dt_o,
  output logic             busy_o,
`ifdef STDP_SCHED_STATS_EN
  output logic [15:0]      upd_count_o,
`endif
  output logic             overflow_o
);

  localparam int NS = 2 * N_SYN;
  localparam int SW = IW + 1;
  localparam logic [TW-1:0] T_MAX = '1;
  localparam logic [TW-1:0] WIN   = TW'(WINDOW);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t          state_q;
  logic [TW-1:0]   pre_t_q [N_SYN];
  logic [TW-1:0]   post_t_q;
  logic [NS-1:0]   pending_q;
  logic [TW-1:0]   dt_q [NS];
  logic [SW-1:0]   last_q;
  logic            upd_valid_q;
  logic [IW-1:0]   upd_idx_q;
  logic            upd_ltp_q;
  logic [TW-1:0]   upd_dt_q;
  logic            overflow_q;

  logic [NS-1:0]   cap;
  logic [TW-1:0]   cap_dt [NS];
  logic            handshake;
  logic [NS-1:0]   clr;
  logic [NS-1:0]   mask;
  logic [NS-1:0]   pending_d;
  logic            win_found;
  logic [SW-1:0]   win;

  // Captures look at timer values from before this edge.
  always_comb begin
    cap = '0;
    for (int i = 0; i < N_SYN; i++) begin
      cap[2*i]      = post_spike_i & ~pre_spike_i[i] & (pre_t_q[i] <= WIN);
      cap_dt[2*i]   = pre_t_q[i];
      cap[2*i+1]    = pre_spike_i[i] & ~post_spike_i & (post_t_q <= WIN);
      cap_dt[2*i+1] = post_t_q;
    end
  end

  assign handshake = upd_valid_q & upd_ready_i;
  assign clr       = handshake ? (NS'(1) << last_q) : '0;
  assign mask      = pending_q & ~clr;
  assign pending_d = mask | cap;

  always_comb begin
    int s;
    s         = 0;
    win_found = 1'b0;
    win       = '0;
    for (int k = 1; k <= NS; k++) begin
      s = (int'(last_q) + k) % NS;
      if (!win_found && mask[s]) begin
        win_found = 1'b1;
        win       = SW'(s);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      for (int i = 0; i < N_SYN; i++) pre_t_q[i] <= T_MAX;
      post_t_q    <= T_MAX;
      pending_q   <= '0;
      for (int s = 0; s < NS; s++) dt_q[s] <= '0;
      last_q      <= SW'(NS - 1);
      upd_valid_q <= 1'b0;
      upd_idx_q   <= '0;
      upd_ltp_q   <= 1'b0;
      upd_dt_q    <= '0;
      overflow_q  <= 1'b0;
    end else begin
      for (int i = 0; i < N_SYN; i++) begin
        if (pre_spike_i[i])          pre_t_q[i] <= TW'(1);
        else if (pre_t_q[i] != T_MAX) pre_t_q[i] <= pre_t_q[i] + TW'(1);
      end
      if (post_spike_i)            post_t_q <= TW'(1);
      else if (post_t_q != T_MAX)  post_t_q <= post_t_q + TW'(1);

      pending_q <= pending_d;
      for (int s = 0; s < NS; s++) begin
        if (cap[s]) dt_q[s] <= cap_dt[s];
      end
      // A slot being retired on this edge is not an overwrite.
      if (|(cap & pending_q & ~clr)) overflow_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (win_found) begin
            state_q     <= ISSUE;
            upd_valid_q <= 1'b1;
            upd_idx_q   <= win[SW-1:1];
            upd_ltp_q   <= ~win[0];
            upd_dt_q    <= dt_q[win];
            last_q      <= win;
          end
        end
        ISSUE: begin
          if (upd_ready_i) begin
            if (win_found) begin
              upd_idx_q <= win[SW-1:1];
              upd_ltp_q <= ~win[0];
              upd_dt_q  <= dt_q[win];
              last_q    <= win;
            end else begin
              state_q     <= IDLE;
              upd_valid_q <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef STDP_SCHED_STATS_EN
  logic [15:0] upd_count_q;
  always_ff @(posedge clk) begin
    if (!rst_n)                                   upd_count_q <= '0;
    else if (handshake && upd_count_q != 16'hFFFF) upd_count_q <= upd_count_q + 16'd1;
  end
  assign upd_count_o = upd_count_q;
`endif

  assign upd_valid_o = upd_valid_q;
  assign upd_idx_o   = upd_idx_q;
  assign upd_ltp_o   = upd_ltp_q;
  assign upd_dt_o    = upd_dt_q;
  assign overflow_o  = overflow_q;
  assign busy_o      = (|pending_q) | upd_valid_q;

endmodule

// File: tb/tb_stdp_update_scheduler.sv
// Scoreboard bench for stdp_update_scheduler: a timestamp-based reference model predicts
// grants into a queue; a negedge monitor compares DUT requests and status against it.
module tb_stdp_update_scheduler;
  localparam int N   = 4;
  localparam int TW  = 8;
  localparam int WIN = 16;
  localparam int NS  = 2 * N;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  pre_spike;
  logic          post_spike;
  logic          upd_valid;
  logic          upd_ready;
  logic [1:0]    upd_idx;
  logic          upd_ltp;
  logic [TW-1:0] upd_dt;
  logic          busy;
  logic          overflow;
`ifdef STDP_SCHED_STATS_EN
  logic [15:0]   upd_count;
`endif

  always #5 clk = ~clk;

  stdp_update_scheduler #(.N_SYN(N), .TW(TW), .WINDOW(WIN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pre_spike_i  (pre_spike),
    .post_spike_i (post_spike),
    .upd_valid_o  (upd_valid),
    .upd_ready_i  (upd_ready),
    .upd_idx_o    (upd_idx),
    .upd_ltp_o    (upd_ltp),
    .upd_dt_o     (upd_dt),
    .busy_o       (busy),
`ifdef STDP_SCHED_STATS_EN
    .upd_count_o  (upd_count),
`endif
    .overflow_o   (overflow)
  );

  typedef struct {
    int idx;
    int ltp;
    int dt;
  } req_t;

  req_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;

  // Reference model: absolute spike timestamps, slot table, current request.
  int now;
  int last_pre [N];
  int last_post;
  bit pend [NS];
  int mdt [NS];
  int mlast, mcur;
  bit mvalid, movf;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) last_pre[i] = -1;
    last_post = -1;
    for (int s = 0; s < NS; s++) begin
      pend[s] = 1'b0;
      mdt[s]  = 0;
    end
    mlast  = NS - 1;
    mcur   = 0;
    mvalid = 1'b0;
    movf   = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic [N-1:0] pre, input logic post,
                            input logic rdy, input logic rst);
    bit cap [NS];
    int cdt [NS];
    int clr;
    bit found;
    now++;
    if (!rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < N; i++) begin
      cap[2*i]   = post && !pre[i] && last_pre[i] >= 0 && (now - last_pre[i]) <= WIN;
      cdt[2*i]   = now - last_pre[i];
      cap[2*i+1] = pre[i] && !post && last_post >= 0 && (now - last_post) <= WIN;
      cdt[2*i+1] = now - last_post;
    end
    clr = (mvalid && rdy) ? mcur : -1;
    if (!mvalid || rdy) begin
      found = 1'b0;
      for (int k = 1; k <= NS && !found; k++) begin
        int s;
        s = (mlast + k) % NS;
        if (pend[s] && s != clr) begin
          found = 1'b1;
          exp_q.push_back('{s / 2, (s % 2 == 0) ? 1 : 0, mdt[s]});
          mcur  = s;
          mlast = s;
        end
      end
      mvalid = found;
    end
    for (int s = 0; s < NS; s++) begin
      if (cap[s]) begin
        if (pend[s] && s != clr) movf = 1'b1;
        pend[s] = 1'b1;
        mdt[s]  = cdt[s];
      end else if (s == clr) begin
        pend[s] = 1'b0;
      end
    end
    for (int i = 0; i < N; i++) if (pre[i]) last_pre[i] = now;
    if (post) last_post = now;
  endtask

  function automatic bit model_busy();
    bit b;
    b = mvalid;
    for (int s = 0; s < NS; s++) b |= pend[s];
    return b;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      check("upd_valid", int'(upd_valid), int'(mvalid));
      check("busy", int'(busy), int'(model_busy()));
      check("overflow", int'(overflow), int'(movf));
      if (upd_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_request @%0t: idx %0d ltp %0d dt %0d, expected none",
                   $time, upd_idx, upd_ltp, upd_dt);
        end else begin
          check("upd_idx", int'(upd_idx), exp_q[0].idx);
          check("upd_ltp", int'(upd_ltp), exp_q[0].ltp);
          check("upd_dt", int'(upd_dt), exp_q[0].dt);
          if (upd_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic cycle(input logic [N-1:0] pre, input logic post,
                       input logic rdy, input logic rst = 1'b1);
    pre_spike  = pre;
    post_spike = post;
    upd_ready  = rdy;
    rst_n      = rst;
    @(posedge clk);
    model_step(pre, post, rdy, rst);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy = 1'b1);
    repeat (n) cycle('0, 1'b0, rdy);
  endtask

  initial begin
    logic [N-1:0] pr;
    now = 0;
    model_reset();
    rst_n = 1'b0; pre_spike = '0; post_spike = 1'b0; upd_ready = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    repeat (3) cycle('0, 1'b0, 1'b1, 1'b0);
    check("rst_valid", int'(upd_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_idx", int'(upd_idx), 0);
    check("rst_ltp", int'(upd_ltp), 0);
    check("rst_dt", int'(upd_dt), 0);

    // LTP: pre[2] then post 5 cycles later
    idle(10);
    cycle(4'b0100, 1'b0, 1'b1);
    idle(4);
    cycle('0, 1'b1, 1'b1);
    idle(6);
    // LTD: post then pre[1] 3 cycles later
    idle(30);
    cycle('0, 1'b1, 1'b1);
    idle(2);
    cycle(4'b0010, 1'b0, 1'b1);
    idle(6);
    // dt beyond window
    idle(30);
    cycle(4'b0001, 1'b0, 1'b1);
    idle(39);
    cycle('0, 1'b1, 1'b1);
    idle(6);
    // all four LTP with ready held low, then drain
    idle(30);
    cycle(4'b1111, 1'b0, 1'b1);
    idle(1);
    cycle('0, 1'b1, 1'b0);
    idle(10, 1'b0);
    idle(8);
    // coincidence, then overwrite of a pending LTP slot
    idle(30);
    cycle(4'b1000, 1'b1, 1'b1);
    idle(6);
    idle(30);
    cycle(4'b0001, 1'b0, 1'b0);
    idle(1, 1'b0);
    cycle('0, 1'b1, 1'b0);
    idle(1, 1'b0);
    cycle('0, 1'b1, 1'b0);
    idle(3, 1'b0);
    check("overflow_directed", int'(overflow), 1);
    idle(6);

    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < N; i++) pr[i] = ($urandom_range(0, 9) == 0);
      cycle(pr, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 599) != 0);
    end
    idle(20);
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
